// File: rtl/fxp_sqrt_rr_share.sv
// Round-robin shared fixed-point square root: NREQ valid/ready requesters feed one
// combinational sqrt datapath, results return on a single tagged, registered channel.
module fxp_sqrt_rr_share #(
  parameter int WII   = 13,
  parameter int WIF   = 13,
  parameter int WOI   = 7,
  parameter int WOF   = 13,
  parameter int ROUND = 1,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*(WII+WIF)-1:0]  req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WOI+WOF-1:0]         res_data,
  output logic                       res_overflow,
  output logic                       res_neg,
  output logic [IDW-1:0]             res_id
);

  localparam int W   = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int SH  = 2 * WOF - WIF;
  localparam int SHL = (SH > 0) ? SH : 0;
  localparam int SHR = (SH < 0) ? -SH : 0;
  localparam int RW0 = W - 1 + SHL;
  localparam int RW  = RW0 + (RW0 % 2);
  localparam int QW  = RW / 2;
  localparam int CW  = (QW + 1 > WO) ? QW + 1 : WO;

  // Radicand is aligned so isqrt lands directly on WOF fraction bits; negatives give 0.
  function automatic logic [WO:0] sqrt_fn(input logic [W-1:0] din);
    logic [RW-1:0]   rad;
    logic [QW-1:0]   root;
    logic [QW+1:0]   rem;
    logic [QW+1:0]   trial;
    logic [CW-1:0]   rnd;
    logic [CW-1:0]   lim;
    logic            ovf;
    logic [WO-1:0]   dout;
    rad  = (RW'(din[W-2:0]) << SHL) >> SHR;
    root = '0;
    rem  = '0;
    for (int i = QW - 1; i >= 0; i--) begin
      rem   = {rem[QW-1:0], rad[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[QW-2:0], 1'b1};
      end else begin
        root = {root[QW-2:0], 1'b0};
      end
    end
    rnd = CW'(root);
    // remainder > root means the exact root is above root + 0.5
    if (ROUND != 0 && rem > {2'b00, root}) rnd = rnd + CW'(1);
    lim  = CW'({WO{1'b1}});
    ovf  = (rnd > lim);
    dout = ovf ? {WO{1'b1}} : rnd[WO-1:0];
    if (din[W-1]) begin
      ovf  = 1'b0;
      dout = '0;
    end
    return {ovf, dout};
  endfunction

  // state | meaning
  // IDLE  | waiting for any requester; grant is combinational
  // CALC  | op_q on the datapath, result registered at the edge
  // RESP  | result held until accepted; may grant the next requester
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, id_q, gnt_idx;
  logic [W-1:0]   op_q;
  logic           gnt_any, grant_en, hs;
  logic [WO-1:0]  sq_out;
  logic           sq_ovf;
  int             idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_en  = !rst && (state == IDLE || (state == RESP && res_ready));
    hs        = grant_en && gnt_any;
    req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;
    case (state)
      IDLE:    if (hs) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = hs ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    {sq_ovf, sq_out} = sqrt_fn(op_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      op_q         <= '0;
      id_q         <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_neg      <= 1'b0;
      res_id       <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_q   <= req_data[gnt_idx*W +: W];
        id_q   <= gnt_idx;
        rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      end
      if (state == CALC) begin
        res_valid    <= 1'b1;
        res_data     <= sq_out;
        res_overflow <= sq_ovf;
        res_neg      <= op_q[W-1];
        res_id       <= id_q;
      end else if (state == RESP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fxp_sqrt_rr_share.sv
// Scoreboard bench: two lockstep instances (WOI=7 and WOI=3) share stimulus;
// expected results are hand-computed and queued, a negedge monitor pops and compares.
module tb_fxp_sqrt_rr_share;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [103:0] req_data;
  logic        res_ready;
  logic [3:0]  req_ready, req_ready2;
  logic        res_valid, res_valid2;
  logic [19:0] res_data;
  logic [15:0] res_data2;
  logic        res_overflow, res_overflow2, res_neg, res_neg2;
  logic [1:0]  res_id, res_id2;

  fxp_sqrt_rr_share #(.WOI(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_neg(res_neg), .res_id(res_id));

  fxp_sqrt_rr_share #(.WOI(3)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready2),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
    .res_overflow(res_overflow2), .res_neg(res_neg2), .res_id(res_id2));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [19:0] d1;
    logic        ov1;
    logic [15:0] d2;
    logic        ov2;
    logic        neg;
  } exp_t;

  exp_t exp_q[$];
  int   resp_cyc[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [19:0] d1, input logic ov1,
                      input logic [15:0] d2, input logic ov2, input logic neg);
    exp_t x;
    x.id = id; x.d1 = d1; x.ov1 = ov1; x.d2 = d2; x.ov2 = ov2; x.neg = neg;
    exp_q.push_back(x);
  endtask

  // results below 8.0 are identical in both instances
  task automatic push_ok(input logic [1:0] id, input logic [15:0] d);
    push(id, {4'h0, d}, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic set_data(input int i, input logic [25:0] v);
    req_data[i*26 +: 26] = v;
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      resp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_response: got id %0d data %h, required no response", res_id, res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_data", 32'(res_data), 32'(e.d1));
        chk("res_overflow", 32'(res_overflow), 32'(e.ov1));
        chk("res_neg", 32'(res_neg), 32'(e.neg));
        chk("res_valid2", 32'(res_valid2), 32'd1);
        chk("res_id2", 32'(res_id2), 32'(e.id));
        chk("res_data2", 32'(res_data2), 32'(e.d2));
        chk("res_overflow2", 32'(res_overflow2), 32'(e.ov2));
        chk("res_neg2", 32'(res_neg2), 32'(e.neg));
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic drive(input int c0, input int c1, input int c2, input int c3);
    int cnt[4];
    logic [3:0] hs;
    int budget;
    cnt = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) req_valid[i] = (cnt[i] > 0);
    budget = 0;
    while ((cnt[0] + cnt[1] + cnt[2] + cnt[3]) != 0 && budget < 200) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (hs[i]) begin
          cnt[i]--;
          if (cnt[i] == 0) req_valid[i] = 1'b0;
        end
      budget++;
    end
    if (budget >= 200) chk("drive_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    chk("pending_before_reset", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    res_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_data", 32'(res_data), 32'd0);
    chk("reset_res_overflow", 32'(res_overflow), 32'd0);
    chk("reset_res_neg", 32'(res_neg), 32'd0);
    chk("reset_res_id", 32'(res_id), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;

    // single request, 4.0 -> 2.0, with latency
    set_data(0, 26'h0008000);
    push_ok(0, 16'h4000);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'h1);
    chk("t1_valid_n", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t1_valid_n1", 32'(res_valid), 32'd0);
    chk("t1_calc_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t1_valid_n2", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // round-robin with all requesters busy
    do_reset();
    set_data(0, 26'h0002000);
    set_data(1, 26'h0012000);
    set_data(2, 26'h0000800);
    set_data(3, 26'h0006000);
    push_ok(0, 16'h2000);
    push_ok(1, 16'h6000);
    push_ok(2, 16'h1000);
    push_ok(3, 16'h376D);
    push_ok(0, 16'h2000);
    push_ok(1, 16'h6000);
    resp_cyc.delete();
    drive(2, 2, 1, 1);
    wait_drain();
    chk("t2_count", 32'(resp_cyc.size()), 32'd6);
    for (int k = 1; k < resp_cyc.size(); k++)
      chk("t2_interval", 32'(resp_cyc[k] - resp_cyc[k-1]), 32'd2);

    // backpressure; req3 withdraws ungranted; req1 zero, req2 negative
    do_reset();
    res_ready = 1'b0;
    set_data(0, 26'h0004000);
    set_data(1, 26'h0000000);
    set_data(2, 26'h3FFE000);
    set_data(3, 26'h0002000);
    push_ok(0, 16'h2D41);
    push_ok(1, 16'h0000);
    push(2, 20'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t3_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b1110;
    @(negedge clk);
    chk("t3_calc_ready", 32'(req_ready), 32'd0);
    chk("t3_calc_valid", 32'(res_valid), 32'd0);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      if (s == 2) req_valid = 4'b0110;
      @(negedge clk);
      chk("t3_hold_valid", 32'(res_valid), 32'd1);
      chk("t3_hold_data", 32'(res_data), 32'h2D41);
      chk("t3_hold_id", 32'(res_id), 32'd0);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drive(0, 0, 1, 0);
    wait_drain();

    // reset during CALC, then boundary and overflow operands
    do_reset();
    set_data(1, 26'h0002000);
    push_ok(1, 16'h2000);
    drive(0, 1, 0, 0);
    wait_drain();
    set_data(0, 26'h0012000);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t6_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_data(0, 26'h0000001);
    set_data(1, 26'h1FFFFFF);
    set_data(2, 26'h0800000);
    set_data(3, 26'h0062000);
    push_ok(0, 16'h005B);
    push(1, 20'h80000, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    push(2, 20'h40000, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    push_ok(3, 16'hE000);
    drive(1, 1, 1, 1);
    wait_drain();
    set_data(2, 26'h0080000);
    push(2, 20'h10000, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    drive(0, 0, 1, 0);
    wait_drain();

    repeat (5) @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
